memory_read: RTL and testbench

MEMORY_READ -- requirements
Module: memory_read

---
 rtl/vector_pkg.sv | 40 ++++
 rtl/memory_read.sv | 202 ++++++++++++++++++++
 tb/tb_memory_read.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// vector_pkg
//   Shared definitions for the vector display list: the traversal state
//   encoding and the layout of one RAM entry. The list writer builds entries
//   with the same field positions, so any change here must be mirrored there.
//
//   Entry layout (18 bits): x=[17:10], y=[9:2], line=[1], pos=[0]
//     line pos
//      0    0   no-op
//      0    1   move current point
//      1    0   draw from current point
//      1    1   terminator (end of frame)
package vector_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    READ      = 4'd1,
    DECODE    = 4'd2,
    REQ       = 4'd3,
    DRAW      = 4'd4,
    FRAME_END = 4'd5,
    RELEASE   = 4'd6
  } state_t;

  // Bit positions of the entry fields
  localparam int X_LSB    = 10;
  localparam int Y_LSB    = 2;
  localparam int LINE_BIT = 1;
  localparam int POS_BIT  = 0;

  // Entry kinds as {line, pos}
  localparam logic [1:0] KIND_NOP  = 2'b00;
  localparam logic [1:0] KIND_MOVE = 2'b01;
  localparam logic [1:0] KIND_DRAW = 2'b10;
  localparam logic [1:0] KIND_TERM = 2'b11;

  function automatic logic [1:0] entry_kind(input logic line, input logic pos);
    return {line, pos};
  endfunction

endpackage

// File: rtl/memory_read.sv
// memory_read
//   Walks a vector display list stored in RAM and hands each drawn segment
//   to a line drawer. Traversal starts when the list writer raises go and
//   ends at a terminator entry (or at the last RAM address), after which a
//   one-cycle halt pulse is issued and the block waits for go to drop.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     go           list in RAM is complete and stable
//     halt         one-cycle pulse, frame traversal finished
//     adrREAD      RAM read address
//     dataREAD     RAM read data, valid one cycle after adrREAD
//     line_start   line request to the drawer, held until line_busy seen
//     line_busy    drawer busy
//     x0,y0,x1,y1  endpoints of the requested line
//     state_debug  current state encoding
module memory_read
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int DATAWIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic                 halt,
  output logic [ADR_WIDTH-1:0] adrREAD,
  input  logic [DATAWIDTH-1:0] dataREAD,
  output logic                 line_start,
  input  logic                 line_busy,
  output logic [OUT_WIDTH-1:0] x0,
  output logic [OUT_WIDTH-1:0] y0,
  output logic [OUT_WIDTH-1:0] x1,
  output logic [OUT_WIDTH-1:0] y1,
  output logic [3:0]           state_debug
);

  localparam logic [ADR_WIDTH-1:0] ADR_LAST = '1;
  localparam logic [ADR_WIDTH-1:0] ADR_ONE  = ADR_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [ADR_WIDTH-1:0]   adr_nxt;
  logic [OUT_WIDTH-1:0]   cur_x, cur_y, cur_x_nxt, cur_y_nxt;
  logic [OUT_WIDTH-1:0]   x0_nxt, y0_nxt, x1_nxt, y1_nxt;
  logic                   halt_nxt, line_start_nxt;

  logic [OUT_WIDTH-1:0]   ent_x, ent_y;
  logic [1:0]             ent_kind;
  logic                   at_last;

  assign ent_x    = dataREAD[X_LSB +: OUT_WIDTH];
  assign ent_y    = dataREAD[Y_LSB +: OUT_WIDTH];
  assign ent_kind = entry_kind(dataREAD[LINE_BIT], dataREAD[POS_BIT]);

  // The last address is never incremented past; finishing an entry there
  // ends the frame as if a terminator had followed.
  assign at_last  = (adrREAD == ADR_LAST);

  assign state_debug = state;

  // All traversal registers, cleared asynchronously so a reset mid-handshake
  // drops line_start and the endpoints without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      adrREAD    <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      halt       <= 1'b0;
      line_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      adrREAD    <= adr_nxt;
      cur_x      <= cur_x_nxt;
      cur_y      <= cur_y_nxt;
      x0         <= x0_nxt;
      y0         <= y0_nxt;
      x1         <= x1_nxt;
      y1         <= y1_nxt;
      halt       <= halt_nxt;
      line_start <= line_start_nxt;
    end
  end

  // Next-state logic. halt and line_start are computed for the state being
  // entered so that the registered versions line up with FRAME_END and REQ.
  always_comb begin
    state_nxt      = state;
    adr_nxt        = adrREAD;
    cur_x_nxt      = cur_x;
    cur_y_nxt      = cur_y;
    x0_nxt         = x0;
    y0_nxt         = y0;
    x1_nxt         = x1;
    y1_nxt         = y1;
    halt_nxt       = 1'b0;
    line_start_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          adr_nxt   = '0;
          cur_x_nxt = '0;
          cur_y_nxt = '0;
          state_nxt = READ;
        end
      end

      READ: begin
        state_nxt = go ? DECODE : IDLE;
      end

      DECODE: begin
        if (!go) begin
          state_nxt = IDLE;
        end else begin
          case (ent_kind)
            KIND_TERM: begin
              state_nxt = FRAME_END;
              halt_nxt  = 1'b1;
            end
            KIND_DRAW: begin
              x0_nxt         = cur_x;
              y0_nxt         = cur_y;
              x1_nxt         = ent_x;
              y1_nxt         = ent_y;
              cur_x_nxt      = ent_x;
              cur_y_nxt      = ent_y;
              state_nxt      = REQ;
              line_start_nxt = 1'b1;
            end
            KIND_MOVE: begin
              cur_x_nxt = ent_x;
              cur_y_nxt = ent_y;
              if (at_last) begin
                state_nxt = FRAME_END;
                halt_nxt  = 1'b1;
              end else begin
                adr_nxt   = adrREAD + ADR_ONE;
                state_nxt = READ;
              end
            end
            default: begin
              // no-op entry
              if (at_last) begin
                state_nxt = FRAME_END;
                halt_nxt  = 1'b1;
              end else begin
                adr_nxt   = adrREAD + ADR_ONE;
                state_nxt = READ;
              end
            end
          endcase
        end
      end

      REQ: begin
        // go is ignored here: an accepted request always runs to completion
        if (line_busy) begin
          state_nxt = DRAW;
        end else begin
          line_start_nxt = 1'b1;
        end
      end

      DRAW: begin
        if (!line_busy) begin
          if (!go) begin
            state_nxt = IDLE;
          end else if (at_last) begin
            state_nxt = FRAME_END;
            halt_nxt  = 1'b1;
          end else begin
            adr_nxt   = adrREAD + ADR_ONE;
            state_nxt = READ;
          end
        end
      end

      FRAME_END: begin
        state_nxt = RELEASE;
      end

      RELEASE: begin
        if (!go) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_read.sv
// tb_memory_read
//   Directed bench for memory_read: a small RAM model with one-cycle read
//   latency, a line drawer model with adjustable acknowledge delay and busy
//   length, and hand-computed expected reads, lines and state encodings.
//   The DUT uses a 4-bit address so the last-address case is reachable.
module tb_memory_read;

  localparam int OW = 8;
  localparam int AW = 4;
  localparam int DW = 18;

  logic          clk;
  logic          rst;
  logic          go;
  logic          halt;
  logic [AW-1:0] adrREAD;
  logic [DW-1:0] dataREAD;
  logic          line_start;
  logic          line_busy;
  logic [OW-1:0] x0, y0, x1, y1;
  logic [3:0]    state_debug;

  logic [DW-1:0] ram [0:15];

  int checks = 0;
  int failures = 0;

  int ackDelay = 1;
  int busyCycles = 3;

  int haltCount = 0;
  int lsCycles = 0;
  int unstable = 0;
  logic [AW-1:0] readLog [$];
  logic [31:0]   lineLog [$];

  memory_read #(
    .OUT_WIDTH(OW),
    .ADR_WIDTH(AW),
    .DATAWIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .halt       (halt),
    .adrREAD    (adrREAD),
    .dataREAD   (dataREAD),
    .line_start (line_start),
    .line_busy  (line_busy),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .state_debug(state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one cycle of read latency
  always @(posedge clk) dataREAD <= ram[adrREAD];

  // Event recorder, sampled on the falling edge
  always @(negedge clk) begin
    if (halt) haltCount <= haltCount + 1;
    if (line_start) lsCycles <= lsCycles + 1;
    if (state_debug == 4'd1) readLog.push_back(adrREAD);
  end

  // Line drawer: sees a request, waits ackDelay cycles, then busy for busyCycles
  initial begin
    logic [AW+4*OW-1:0] snap;
    line_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (line_start && rst) begin
        lineLog.push_back({x0, y0, x1, y1});
        snap = {adrREAD, x0, y0, x1, y1};
        for (int i = 0; i < ackDelay; i++) begin
          @(negedge clk);
          if ({adrREAD, x0, y0, x1, y1} != snap) unstable = unstable + 1;
        end
        line_busy = 1'b1;
        for (int i = 0; i < busyCycles; i++) @(negedge clk);
        line_busy = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] mkEntry(input logic [7:0] x, input logic [7:0] y,
                                            input logic line, input logic pos);
    return {x, y, line, pos};
  endfunction

  function automatic logic [31:0] seg(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return {a, b, c, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic goVal);
    @(negedge clk);
    go = goVal;
  endtask

  task automatic clearRam();
    for (int i = 0; i < 16; i++) ram[i] = '0;
  endtask

  task automatic waitHalt(input string tag, input int maxCycles);
    bit seen = 0;
    for (int n = 0; n < maxCycles && !seen; n++) begin
      @(negedge clk);
      if (halt) seen = 1;
    end
    if (!seen) checkOutput({tag, "_halt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitState(input string tag, input logic [3:0] st, input int maxCycles);
    bit seen = 0;
    for (int n = 0; n < maxCycles && !seen; n++) begin
      @(negedge clk);
      if (state_debug == st) seen = 1;
    end
    if (!seen) checkOutput({tag, "_state_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkReadSeq(input string tag, input int base, input int n);
    checkOutput({tag, "_read_count"}, readLog.size() - base, n);
    for (int i = 0; i < n && base + i < readLog.size(); i++)
      checkOutput({tag, "_read_adr"}, 32'(readLog[base + i]), i);
  endtask

  task automatic finishFrame(input string tag);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput({tag, "_idle"}, 32'(state_debug), 32'd0);
  endtask

  initial begin
    int rb, lb, hb, lsb, ub;
    rst = 1'b0;
    go = 1'b0;
    clearRam();

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 32'(state_debug), 32'd0);
    checkOutput("reset_adr", 32'(adrREAD), 32'd0);
    checkOutput("reset_outs", {halt, line_start, x0, y0, x1, y1}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Move, draw, terminator; release only after go toggles
    $display("[TB] frame with one line");
    clearRam();
    ram[0] = mkEntry(8'd0, 8'd0, 1'b0, 1'b1);
    ram[1] = mkEntry(8'd10, 8'd20, 1'b1, 1'b0);
    ram[2] = mkEntry(8'd0, 8'd0, 1'b1, 1'b1);
    rb = readLog.size(); lb = lineLog.size(); hb = haltCount;
    ackDelay = 1; busyCycles = 3;
    applyStimulus(1'b1);
    waitHalt("t1", 100);
    @(negedge clk);
    checkOutput("t1_halt_pulse", 32'(halt), 32'd0);
    checkOutput("t1_release", 32'(state_debug), 32'd6);
    repeat (5) @(negedge clk);
    checkOutput("t1_halt_count", haltCount - hb, 32'd1);
    checkOutput("t1_still_release", 32'(state_debug), 32'd6);
    checkOutput("t1_adr_hold", 32'(adrREAD), 32'd2);
    checkReadSeq("t1", rb, 3);
    checkOutput("t1_line_count", lineLog.size() - lb, 32'd1);
    if (lineLog.size() > lb) checkOutput("t1_line", lineLog[lb], seg(0, 0, 10, 20));
    finishFrame("t1");

    // Two chained lines, addresses step 0..3
    $display("[TB] frame with two chained lines");
    clearRam();
    ram[0] = mkEntry(8'd50, 8'd60, 1'b0, 1'b1);
    ram[1] = mkEntry(8'd70, 8'd80, 1'b1, 1'b0);
    ram[2] = mkEntry(8'd90, 8'd10, 1'b1, 1'b0);
    ram[3] = mkEntry(8'd0, 8'd0, 1'b1, 1'b1);
    rb = readLog.size(); lb = lineLog.size(); hb = haltCount;
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("t2_restart_state", 32'(state_debug), 32'd1);
    checkOutput("t2_restart_adr", 32'(adrREAD), 32'd0);
    waitHalt("t2", 150);
    repeat (2) @(negedge clk);
    checkOutput("t2_halt_count", haltCount - hb, 32'd1);
    checkReadSeq("t2", rb, 4);
    checkOutput("t2_line_count", lineLog.size() - lb, 32'd2);
    if (lineLog.size() > lb + 1) begin
      checkOutput("t2_line_a", lineLog[lb], seg(50, 60, 70, 80));
      checkOutput("t2_line_b", lineLog[lb + 1], seg(70, 80, 90, 10));
    end
    finishFrame("t2");

    // Slow acknowledge: request held, address and endpoints steady
    $display("[TB] slow drawer acknowledge");
    clearRam();
    ram[0] = mkEntry(8'd0, 8'd0, 1'b0, 1'b1);
    ram[1] = mkEntry(8'd4, 8'd4, 1'b1, 1'b0);
    ram[2] = mkEntry(8'd0, 8'd0, 1'b1, 1'b1);
    lb = lineLog.size(); lsb = lsCycles; ub = unstable;
    ackDelay = 5;
    applyStimulus(1'b1);
    waitHalt("t3", 100);
    @(negedge clk);
    checkOutput("t3_ls_cycles", lsCycles - lsb, 32'd6);
    checkOutput("t3_stable", unstable - ub, 32'd0);
    checkOutput("t3_line_count", lineLog.size() - lb, 32'd1);
    if (lineLog.size() > lb) checkOutput("t3_line", lineLog[lb], seg(0, 0, 4, 4));
    ackDelay = 1;
    finishFrame("t3");

    // No-op between move and draw
    $display("[TB] no-op entry skipped");
    clearRam();
    ram[0] = mkEntry(8'd1, 8'd1, 1'b0, 1'b1);
    ram[1] = mkEntry(8'd5, 8'd5, 1'b0, 1'b0);
    ram[2] = mkEntry(8'd9, 8'd9, 1'b1, 1'b0);
    ram[3] = mkEntry(8'd0, 8'd0, 1'b1, 1'b1);
    rb = readLog.size(); lb = lineLog.size();
    applyStimulus(1'b1);
    waitHalt("t4", 150);
    @(negedge clk);
    checkReadSeq("t4", rb, 4);
    checkOutput("t4_line_count", lineLog.size() - lb, 32'd1);
    if (lineLog.size() > lb) checkOutput("t4_line", lineLog[lb], seg(1, 1, 9, 9));
    finishFrame("t4");

    // Last address without terminator: processed, then frame ends, no wrap
    $display("[TB] last address ends frame");
    clearRam();
    ram[14] = mkEntry(8'd3, 8'd4, 1'b0, 1'b1);
    ram[15] = mkEntry(8'd20, 8'd30, 1'b1, 1'b0);
    rb = readLog.size(); lb = lineLog.size(); hb = haltCount;
    applyStimulus(1'b1);
    waitHalt("t5", 200);
    repeat (3) @(negedge clk);
    checkOutput("t5_adr_no_wrap", 32'(adrREAD), 32'd15);
    checkOutput("t5_halt_count", haltCount - hb, 32'd1);
    checkReadSeq("t5", rb, 16);
    checkOutput("t5_line_count", lineLog.size() - lb, 32'd1);
    if (lineLog.size() > lb) checkOutput("t5_line", lineLog[lb], seg(3, 4, 20, 30));
    finishFrame("t5");

    // go dropped while reading address 2
    $display("[TB] go dropped during read");
    clearRam();
    ram[0] = mkEntry(8'd1, 8'd2, 1'b0, 1'b1);
    ram[1] = mkEntry(8'd3, 8'd4, 1'b0, 1'b1);
    ram[2] = mkEntry(8'd5, 8'd6, 1'b0, 1'b1);
    ram[3] = mkEntry(8'd7, 8'd8, 1'b0, 1'b1);
    ram[4] = mkEntry(8'd0, 8'd0, 1'b1, 1'b1);
    hb = haltCount;
    applyStimulus(1'b1);
    begin
      bit seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        if (state_debug == 4'd1 && adrREAD == 4'd2) seen = 1;
      end
      if (!seen) checkOutput("t6_read2_timeout", 32'd0, 32'd1);
    end
    go = 1'b0;
    @(negedge clk);
    checkOutput("t6_abort_idle", 32'(state_debug), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t6_no_halt", haltCount - hb, 32'd0);
    checkOutput("t6_stay_idle", 32'(state_debug), 32'd0);

    // Reset mid-DRAW clears outputs before the next clock edge
    $display("[TB] reset during draw");
    clearRam();
    ram[0] = mkEntry(8'd0, 8'd0, 1'b0, 1'b1);
    ram[1] = mkEntry(8'd10, 8'd20, 1'b1, 1'b0);
    ram[2] = mkEntry(8'd0, 8'd0, 1'b1, 1'b1);
    busyCycles = 10;
    applyStimulus(1'b1);
    waitState("t7", 4'd4, 50);
    checkOutput("t7_pre_x1", 32'(x1), 32'd10);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t7_rst_state", 32'(state_debug), 32'd0);
    checkOutput("t7_rst_adr", 32'(adrREAD), 32'd0);
    checkOutput("t7_rst_outs", {halt, line_start, x0, y0, x1, y1}, 32'd0);
    go = 1'b0;
    begin
      bit idle = 0;
      for (int n = 0; n < 30 && !idle; n++) begin
        @(negedge clk);
        if (!line_busy) idle = 1;
      end
      if (!idle) checkOutput("t7_busy_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t7_post_idle", 32'(state_debug), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
